// File: rtl/vga_timing_generator.sv
// Raster timing generator: one pixel per enabled clk, with registered sync, display-enable,
// coordinate, strobe and frame-count outputs decoded from the position being entered.
module vga_timing_generator #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 400,
  parameter int   V_FRONT   = 12,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 35,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   CW        = 10,
  parameter int   FW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_en,
  input  logic          restart,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          de,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START   = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END     = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END     = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_wrap;
  logic          origin;
  logic          h_vis;
  logic          v_vis;
  logic          hs_act;
  logic          vs_act;
  logic          first_pending;

  // Next position and its decodes; outputs register these so they line up with the counters.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    origin = h_wrap && (v_cnt == V_LAST);
    h_vis  = (h_nxt < H_VIS);
    v_vis  = (v_nxt < V_VIS);
    hs_act = (h_nxt >= HS_START) && (h_nxt < HS_END);
    vs_act = (v_nxt >= VS_START) && (v_nxt < VS_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      HSYNC         <= ~HSYNC_POL;
      VSYNC         <= ~VSYNC_POL;
      de            <= 1'b0;
      X             <= '0;
      Y             <= '0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      frame_count   <= '0;
      first_pending <= 1'b1;
    end else if (restart) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      HSYNC       <= ~HSYNC_POL;
      VSYNC       <= ~VSYNC_POL;
      de          <= 1'b0;
      X           <= '0;
      Y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pixel_en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      HSYNC       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      VSYNC       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      de          <= h_vis && v_vis;
      X           <= (h_vis && v_vis) ? h_nxt : '0;
      Y           <= v_vis ? v_nxt : '0;
      line_start  <= h_wrap;
      frame_start <= origin;
      // The entry into (0,0) right after reset opens frame 0 rather than closing one.
      if (origin) begin
        first_pending <= 1'b0;
        if (!first_pending) begin
          frame_count <= frame_count + 1'b1;
        end
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: a linear-position raster model predicts each cycle's outputs for a
// default-sized and a tiny configuration; a monitor compares them against both instances.
module tb_vga_timing_generator;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit hpol, vpol;
    int fw;
  } cfg_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, pixel_en, restart;

  logic       hs0, vs0, de0, ls0, fs0;
  logic [9:0] x0, y0;
  logic [7:0] fc0;
  logic       hs1, vs1, de1, ls1, fs1;
  logic [2:0] x1, y1;
  logic [1:0] fc1;

  int vectors = 0;
  int miscompares = 0;

  cfg_t cfg[2];
  int   pos[2];
  int   fcnt[2];
  bit   first[2];
  bit   lstr[2];
  bit   fstr[2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  vga_timing_generator dut0 (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .restart(restart),
    .HSYNC(hs0), .VSYNC(vs0), .de(de0), .X(x0), .Y(y0),
    .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
  );

  vga_timing_generator #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(3), .FW(2)
  ) dut1 (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .restart(restart),
    .HSYNC(hs1), .VSYNC(vs1), .de(de1), .X(x1), .Y(y1),
    .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  function automatic exp_t predict(cfg_t c, int p, bit l, bit f, int count);
    exp_t e;
    int ht = c.hv + c.hf + c.hs + c.hb;
    int h = p % ht;
    int v = p / ht;
    bit hact = (h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hs);
    bit vact = (v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vs);
    e.de = (h < c.hv) && (v < c.vv);
    e.hs = hact ? c.hpol : !c.hpol;
    e.vs = vact ? c.vpol : !c.vpol;
    e.x  = e.de ? 10'(h) : 10'd0;
    e.y  = (v < c.vv) ? 10'(v) : 10'd0;
    e.ls = l;
    e.fs = f;
    e.fc = 8'(count);
    return e;
  endfunction

  function automatic string show(exp_t e);
    return $sformatf("hs=%0d vs=%0d de=%0d x=%0d y=%0d ls=%0d fs=%0d fc=%0d",
                     e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.fc);
  endfunction

  task automatic step(int i, bit r, bit rs, bit en);
    int ht = cfg[i].hv + cfg[i].hf + cfg[i].hs + cfg[i].hb;
    int n  = ht * (cfg[i].vv + cfg[i].vf + cfg[i].vs + cfg[i].vb);
    if (r) begin
      pos[i] = n - 1; fcnt[i] = 0; first[i] = 1'b1; lstr[i] = 1'b0; fstr[i] = 1'b0;
    end else if (rs) begin
      pos[i] = n - 1; lstr[i] = 1'b0; fstr[i] = 1'b0;
    end else if (en) begin
      pos[i]  = (pos[i] + 1) % n;
      lstr[i] = (pos[i] % ht) == 0;
      fstr[i] = pos[i] == 0;
      if (fstr[i]) begin
        if (first[i]) first[i] = 1'b0;
        else fcnt[i] = (fcnt[i] + 1) % (1 << cfg[i].fw);
      end
    end else begin
      lstr[i] = 1'b0; fstr[i] = 1'b0;
    end
    if (i == 0) q0.push_back(predict(cfg[0], pos[0], lstr[0], fstr[0], fcnt[0]));
    else        q1.push_back(predict(cfg[1], pos[1], lstr[1], fstr[1], fcnt[1]));
  endtask

  task automatic apply(bit r, bit rs, bit en);
    @(negedge clk);
    reset = r; restart = rs; pixel_en = en;
    step(0, r, rs, en);
    step(1, r, rs, en);
  endtask

  // Monitor: every clk edge presents one output vector per instance.
  initial begin
    exp_t want, got;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() == 0 || q1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL scoreboard_empty: got q0=%0d q1=%0d entries, required >=1", q0.size(), q1.size());
      end else begin
        want = q0.pop_front();
        got  = {hs0, vs0, de0, x0, y0, ls0, fs0, fc0};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL default_cfg t=%0t: got %s, required %s", $time, show(got), show(want));
        end
        want = q1.pop_front();
        got  = {hs1, vs1, de1, 7'd0, x1, 7'd0, y1, ls1, fs1, 6'd0, fc1};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL small_cfg t=%0t: got %s, required %s", $time, show(got), show(want));
        end
      end
    end
  end

  initial begin
    cfg[0] = '{hv:640, hf:16, hs:96, hb:48, vv:400, vf:12, vs:2, vb:35, hpol:1'b0, vpol:1'b1, fw:8};
    cfg[1] = '{hv:4, hf:1, hs:1, hb:1, vv:3, vf:1, vs:1, vb:1, hpol:1'b1, vpol:1'b1, fw:2};
    reset = 1'b1; pixel_en = 1'b0; restart = 1'b0;

    // Held in reset, pixel_en toggling must not move anything.
    for (int k = 0; k < 20; k++) apply(1'b1, 1'b0, 1'(($urandom % 2)));
    // Continuous enable: covers several default lines and many small-config frame wraps.
    for (int k = 0; k < 12000; k++) apply(1'b0, 1'b0, 1'b1);
    // One enable every third clk.
    for (int k = 0; k < 6000; k++) apply(1'b0, 1'b0, (k % 3) == 0);
    // Random enable with occasional restart (sometimes coinciding with pixel_en).
    for (int k = 0; k < 20000; k++)
      apply(1'b0, $urandom_range(0, 699) == 0, $urandom_range(0, 3) != 0);
    // Reset raised between edges mid-frame, then a clean restart of the raster.
    @(posedge clk);
    #3 reset = 1'b1;
    apply(1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4000; k++) apply(1'b0, 1'b0, $urandom_range(0, 4) != 0);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised single-clock raster timing generator that supersedes the row-clocked vertical sync counter. It advances one pixel per enabled `clk` cycle and maintains horizontal and vertical counters. From them it produces HSYNC, VSYNC, display-enable, pixel coordinates, line/frame strobes and a frame counter. It sits between the pixel-clock enable source and the iTalos frame renderer/VGA pins.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, HSYNC pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 400, visible lines per frame
- `V_FRONT`, 12, vertical front porch (lines)
- `V_SYNC`, 2, VSYNC pulse width (lines)
- `V_BACK`, 35, vertical back porch (lines)
- `HSYNC_POL`, 0, active level of HSYNC (1 = active-high)
- `VSYNC_POL`, 1, active level of VSYNC
- `CW`, 10, counter/coordinate width; 2^CW ≥ max(H_TOTAL, V_TOTAL)
- `FW`, 8, frame counter width
- `clk` in 1: single system clock; all state changes on its rising edge
- `reset` in 1: asynchronous, active-high
- `pixel_en` in 1: advance one pixel on this clk edge
- `restart` in 1: synchronous realign to pre-frame position
- `HSYNC` out 1: horizontal sync, polarity per `HSYNC_POL`
- `VSYNC` out 1: vertical sync, polarity per `VSYNC_POL`
- `de` out 1: display enable, high in the visible area
- `X` out CW: visible column, 0 outside visible area
- `Y` out CW: visible row, 0 outside visible rows
- `line_start` out 1: one-clk strobe on entering column 0
- `frame_start` out 1: one-clk strobe on entering (0,0)
- `frame_count` out FW: completed-frame count, wraps

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is the same sum over the V_ parameters (default 449).
- Line order: visible, front porch, sync, back porch. Frame order is the same, in lines.
- Internal `h_cnt` runs 0..H_TOTAL-1 and `v_cnt` runs 0..V_TOTAL-1.
- On `pixel_en`:
  - `h_cnt` increments and wraps to 0 at H_TOTAL-1.
  - `v_cnt` increments only when `h_cnt` wraps, and itself wraps to 0 at V_TOTAL-1.
  - No `pixel_en` means every counter and output holds.
- Reset and `restart` load `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1. The first subsequent `pixel_en` therefore enters (0,0).
- `restart` has priority over `pixel_en` in the same cycle. It does not clear `frame_count`; only `reset` does.
- Decodes, all evaluated on the counter values being entered:
  - `de` = h<H_VISIBLE && v<V_VISIBLE.
  - HSYNC is active for H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC, inactive otherwise.
  - VSYNC is active for V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC, inactive otherwise.
  - VSYNC changes only at h=0 transitions.
  - `X` = h when `de`, else 0.
  - `Y` = v when v<V_VISIBLE, else 0.
- Strobes:
  - `line_start` = 1 for the single clk cycle after the edge entering h=0.
  - `frame_start` = 1 for the single clk cycle after the edge entering (0,0). It coincides with `line_start`.
  - Strobes do not stretch with slow `pixel_en`.
- `frame_count` increments, modulo 2^FW, on the edge that enters (0,0). The first entry after reset does not count, so the value is the number of completed frames.

## Timing
- All outputs are registered and glitch-free. They reflect the new counter position on the same edge that the counters update: zero-cycle lag, no combinational path from inputs to outputs.
- Reset values:
  - HSYNC = ~HSYNC_POL, VSYNC = ~VSYNC_POL
  - `de`=0, X=0, Y=0
  - `line_start`=0, `frame_start`=0, `frame_count`=0
- `restart` produces the same output values one clk later, except `frame_count`.
- Reset asserted mid-frame takes effect immediately (asynchronous). After deassertion, the first `pixel_en` edge starts a clean frame.
- Pulse durations are measured in enabled pixels. With `pixel_en` at 1/N duty, every duration scales by N clk cycles; strobes remain 1 clk.

## Test plan
- Reset, then hold `pixel_en`=0 for 20 clk: HSYNC=1, VSYNC=0, de=0, X=Y=0, strobes 0, frame_count=0 throughout (defaults).
- Release reset, `pixel_en`=1 continuous (defaults):
  - first edge gives frame_start=line_start=1 (one clk), de=1, X=0, Y=0
  - enabled pixel 639 gives X=639; pixel 640 gives de=0, X=0
  - HSYNC low exactly for enabled pixels 656..751 of every line
- Continuous run (defaults):
  - VSYNC high exactly for lines 412..413 (1600 enabled pixels)
  - Y=399 on line 399, Y=0 from line 400
  - after 359200 enabled pixels, frame_start pulses and frame_count=1
- `pixel_en` asserted every 3rd clk: HSYNC low lasts 288 clk, line_start stays 1 clk wide, and the X sequence is identical to the continuous case.
- `restart` asserted mid-line 200 together with `pixel_en`: next clk shows de=0, HSYNC inactive, X=Y=0, frame_count unchanged; the next `pixel_en` gives frame_start.
- Small config (H 4/1/1/1, V 3/1/1/1, HSYNC_POL=1, FW=2): HSYNC high at h=5, VSYNC high at v=4, and frame_count wraps 3→0 after 4 frames (each 42 enabled pixels).
